// File: rtl/cpu_reset_sequencer.sv
// Sequences device and CPU reset release behind DDR calibration, with a
// calibration watchdog, button-driven re-reset and a global enable.
module cpu_reset_sequencer #(
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned CALIB_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button_rflag,
    input  logic       sw_enable,
    input  logic       calib_done,
    output logic       dev_rstn,
    output logic       cpu_rstn,
    output logic       busy,
    output logic       timeout_err,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        HELD       = 3'd0,
        WAIT_CALIB = 3'd1,
        DEV_REL    = 3'd2,
        RUN        = 3'd3,
        DRAIN      = 3'd4,
        ERR        = 3'd5
    } state_t;

    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] CALIB_LAST = 16'(CALIB_TIMEOUT - 1);

    state_t      state;
    state_t      state_n;
    logic [15:0] cnt;

    always_comb begin
        state_n = state;
        case (state)
            HELD: begin
                if (button_rflag) state_n = WAIT_CALIB;
            end
            WAIT_CALIB: begin
                if (calib_done)          state_n = DEV_REL;
                else if (cnt == CALIB_LAST) state_n = ERR;
            end
            DEV_REL: begin
                if (!calib_done)           state_n = ERR;
                else if (cnt == HOLD_LAST) state_n = RUN;
            end
            RUN: begin
                if (!calib_done)        state_n = ERR;
                else if (button_rflag)  state_n = DRAIN;
            end
            DRAIN: begin
                if (cnt == HOLD_LAST) state_n = WAIT_CALIB;
            end
            ERR: begin
                if (button_rflag) state_n = DRAIN;
            end
            default: state_n = HELD;
        endcase
        // Losing the enable beats every other transition, including from HELD.
        if (!sw_enable) state_n = HELD;
    end

    // Outputs are decoded from the next state so they change on the same
    // edge that the state does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HELD;
            cnt         <= '0;
            dev_rstn    <= 1'b0;
            cpu_rstn    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            seq_state   <= '0;
        end else begin
            state <= state_n;
            if (state_n != state) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 16'd1;
            end
            dev_rstn    <= (state_n == DEV_REL) || (state_n == RUN);
            cpu_rstn    <= (state_n == RUN);
            busy        <= (state_n == WAIT_CALIB) || (state_n == DEV_REL) ||
                           (state_n == DRAIN);
            timeout_err <= (state_n == ERR);
            seq_state   <= state_n;
        end
    end

endmodule

// File: tb/tb_cpu_reset_sequencer.sv
// Directed bench for cpu_reset_sequencer: nominal release, timeout, calibration
// loss, re-reset, enable priority and asynchronous reset.
module tb_cpu_reset_sequencer;

    logic       clk;
    logic       rst;
    logic       button_rflag;
    logic       sw_enable;
    logic       calib_done;
    logic       dev_rstn;
    logic       cpu_rstn;
    logic       busy;
    logic       timeout_err;
    logic [2:0] seq_state;

    int unsigned vectors;
    int unsigned miscompares;

    cpu_reset_sequencer #(
        .HOLD_CYCLES   (16),
        .CALIB_TIMEOUT (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .button_rflag (button_rflag),
        .sw_enable    (sw_enable),
        .calib_done   (calib_done),
        .dev_rstn     (dev_rstn),
        .cpu_rstn     (cpu_rstn),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .seq_state    (seq_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on the cycle where calib_done=1 and the next edge enters DEV_REL.
    task automatic expect_release(input string tag);
        tick();
        check({tag, "_devrel_state"}, 16'(seq_state), 16'd2);
        check({tag, "_devrel_dev"},   16'(dev_rstn),  16'd1);
        check({tag, "_devrel_cpu"},   16'(cpu_rstn),  16'd0);
        repeat (15) tick();
        check({tag, "_hold_last_cpu"}, 16'(cpu_rstn), 16'd0);
        tick();
        check({tag, "_run_state"}, 16'(seq_state), 16'd3);
        check({tag, "_run_cpu"},   16'(cpu_rstn),  16'd1);
        check({tag, "_run_busy"},  16'(busy),      16'd0);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        button_rflag = 1'b0;
        sw_enable    = 1'b0;
        calib_done   = 1'b0;
        #2;
        check("rst_state", 16'(seq_state),   16'd0);
        check("rst_dev",   16'(dev_rstn),    16'd0);
        check("rst_cpu",   16'(cpu_rstn),    16'd0);
        check("rst_busy",  16'(busy),        16'd0);
        check("rst_terr",  16'(timeout_err), 16'd0);
        tick();
        tick();
        rst        = 1'b0;
        sw_enable  = 1'b1;
        calib_done = 1'b1;
        repeat (3) tick();
        check("no_autostart", 16'(seq_state), 16'd0);

        // Nominal release
        button_rflag = 1'b1;
        tick();
        button_rflag = 1'b0;
        check("nom_wait_state", 16'(seq_state), 16'd1);
        check("nom_wait_busy",  16'(busy),      16'd1);
        check("nom_wait_dev",   16'(dev_rstn),  16'd0);
        expect_release("nom");

        // Calibration loss for one cycle in RUN
        calib_done = 1'b0;
        tick();
        calib_done = 1'b1;
        check("loss_state", 16'(seq_state),   16'd5);
        check("loss_dev",   16'(dev_rstn),    16'd0);
        check("loss_cpu",   16'(cpu_rstn),    16'd0);
        check("loss_terr",  16'(timeout_err), 16'd1);
        tick();
        check("err_sticky", 16'(seq_state), 16'd5);

        // Button in ERR -> DRAIN -> WAIT_CALIB -> release
        button_rflag = 1'b1;
        tick();
        button_rflag = 1'b0;
        check("err_drain_state", 16'(seq_state),   16'd4);
        check("err_drain_terr",  16'(timeout_err), 16'd0);
        check("err_drain_busy",  16'(busy),        16'd1);
        repeat (15) tick();
        check("drain_last", 16'(seq_state), 16'd4);
        tick();
        check("drain_exit", 16'(seq_state), 16'd1);
        expect_release("err_rel");

        // Re-reset from RUN, with a stray button mid-DRAIN
        button_rflag = 1'b1;
        tick();
        button_rflag = 1'b0;
        check("rr_drain_state", 16'(seq_state), 16'd4);
        check("rr_drain_dev",   16'(dev_rstn),  16'd0);
        check("rr_drain_cpu",   16'(cpu_rstn),  16'd0);
        repeat (4) tick();
        button_rflag = 1'b1;
        tick();
        button_rflag = 1'b0;
        repeat (10) tick();
        check("rr_drain_last", 16'(seq_state), 16'd4);
        tick();
        check("rr_wait_state", 16'(seq_state), 16'd1);
        expect_release("rr");

        // Enable dropped in RUN
        sw_enable = 1'b0;
        tick();
        check("swoff_state", 16'(seq_state), 16'd0);
        check("swoff_dev",   16'(dev_rstn),  16'd0);
        check("swoff_cpu",   16'(cpu_rstn),  16'd0);

        // Calibration timeout with CALIB_TIMEOUT=100
        sw_enable    = 1'b1;
        calib_done   = 1'b0;
        button_rflag = 1'b1;
        tick();
        button_rflag = 1'b0;
        check("to_wait", 16'(seq_state), 16'd1);
        repeat (99) tick();
        check("to_last_wait", 16'(seq_state),   16'd1);
        check("to_last_terr", 16'(timeout_err), 16'd0);
        tick();
        check("to_err_state", 16'(seq_state),   16'd5);
        check("to_err_terr",  16'(timeout_err), 16'd1);
        check("to_err_busy",  16'(busy),        16'd0);
        button_rflag = 1'b1;
        tick();
        button_rflag = 1'b0;
        check("to_drain_state", 16'(seq_state),   16'd4);
        check("to_drain_terr",  16'(timeout_err), 16'd0);
        repeat (16) tick();
        check("to_drain_exit", 16'(seq_state), 16'd1);

        // Enable low beats button and calib_done rising together
        sw_enable    = 1'b0;
        button_rflag = 1'b1;
        calib_done   = 1'b1;
        tick();
        check("prio_state", 16'(seq_state), 16'd0);
        check("prio_busy",  16'(busy),      16'd0);
        tick();
        check("prio_held_btn", 16'(seq_state), 16'd0);
        button_rflag = 1'b0;

        // calib_done wins over timeout on the final count
        sw_enable    = 1'b1;
        calib_done   = 1'b0;
        button_rflag = 1'b1;
        tick();
        button_rflag = 1'b0;
        repeat (99) tick();
        calib_done = 1'b1;
        tick();
        check("win_state", 16'(seq_state),   16'd2);
        check("win_terr",  16'(timeout_err), 16'd0);
        check("win_dev",   16'(dev_rstn),    16'd1);

        // Asynchronous reset mid-DEV_REL, between clock edges
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", 16'(seq_state), 16'd0);
        check("arst_dev",   16'(dev_rstn),  16'd0);
        check("arst_cpu",   16'(cpu_rstn),  16'd0);
        check("arst_busy",  16'(busy),      16'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("arst_no_autostart", 16'(seq_state), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
